// File: rtl/cpu_run_ctrl.sv
// Run/boot controller around CPU_Core, RAM and ROM: preloads data RAM, pulses the
// core reset, then runs the core until an ebreak is fetched or the watchdog expires.
module cpu_run_ctrl #(
   parameter int          ADDR_W     = 10,
   parameter int          DATA_W     = 32,
   parameter int          INIT_WORDS = 16,
   parameter int          RST_CYCLES = 2,
   parameter int          MAX_CYCLES = 3000,
   parameter logic [31:0] HALT_INSN  = 32'h00100073
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              init_valid,
   input  logic [DATA_W-1:0] init_data,
   output logic              init_ready,
   output logic              cpu_RSTn,
   input  logic [DATA_W-1:0] Instruction,
   input  logic              core_MemWrite,
   input  logic              core_MemRead,
   input  logic [ADDR_W-1:0] core_address,
   input  logic [DATA_W-1:0] core_write_data,
   output logic              MemWrite,
   output logic              MemRead,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [31:0]       cycle_count
);

   localparam int PTR_W = (INIT_WORDS > 0) ? $clog2(INIT_WORDS + 1) : 1;
   localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CORE_RST,
      S_RUN,
      S_DONE,
      S_TIMEOUT
   } state_t;

   state_t            state;
   logic [PTR_W-1:0]  ptr;
   logic [RC_W-1:0]   rst_cnt;
   logic              handshake;
   logic              halt_seen;
   logic [31:0]       next_count;

   assign init_ready = (state == S_LOAD);
   assign handshake  = init_ready && init_valid;
   assign cpu_RSTn   = (state == S_RUN);
   assign busy       = (state == S_LOAD) || (state == S_CORE_RST) || (state == S_RUN);
   assign halt_seen  = (Instruction == DATA_W'(HALT_INSN));
   assign next_count = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

   // RAM port is owned by the preload stream in LOAD and by the core in RUN; idle otherwise
   always_comb begin
      MemWrite   = 1'b0;
      MemRead    = 1'b0;
      address    = '0;
      write_data = '0;
      case (state)
         S_LOAD: begin
            if (handshake) begin
               MemWrite   = 1'b1;
               address    = ADDR_W'(ptr);
               write_data = init_data;
            end
         end
         S_RUN: begin
            MemWrite   = core_MemWrite;
            MemRead    = core_MemRead;
            address    = core_address;
            write_data = core_write_data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         ptr         <= '0;
         rst_cnt     <= '0;
         cycle_count <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
               if (state == S_DONE)    done    <= 1'b1;
               if (state == S_TIMEOUT) timeout <= 1'b1;
               if (start) begin
                  done        <= 1'b0;
                  timeout     <= 1'b0;
                  cycle_count <= '0;
                  ptr         <= '0;
                  rst_cnt     <= '0;
                  state       <= (INIT_WORDS == 0) ? S_CORE_RST : S_LOAD;
               end
            end
            S_LOAD: begin
               if (handshake) begin
                  ptr <= ptr + 1'b1;
                  if (ptr == PTR_W'(INIT_WORDS - 1)) begin
                     rst_cnt <= '0;
                     state   <= S_CORE_RST;
                  end
               end
            end
            S_CORE_RST: begin
               if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                  state <= S_RUN;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            S_RUN: begin
               // halt takes priority over a watchdog expiry landing on the same cycle
               cycle_count <= next_count;
               if (halt_seen) begin
                  state <= S_DONE;
               end else if (next_count >= 32'(MAX_CYCLES)) begin
                  state <= S_TIMEOUT;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with a toy straight-line core (PC + ROM) and a RAM
// scoreboard; run outcomes come from a table plus randomized halt positions.
module tb_cpu_run_ctrl;

   localparam int          ADDR_W     = 10;
   localparam int          DATA_W     = 32;
   localparam int          INIT_WORDS = 4;
   localparam int          RST_CYCLES = 2;
   localparam int          MAX_CYCLES = 50;
   localparam logic [31:0] HALT       = 32'h00100073;
   localparam logic [31:0] NOP        = 32'h00000013;

   logic              CLK = 1'b0;
   logic              RST;
   logic              start;
   logic              init_valid;
   logic [DATA_W-1:0] init_data;
   logic              init_ready;
   logic              cpu_RSTn;
   logic [DATA_W-1:0] Instruction;
   logic              core_MemWrite;
   logic              core_MemRead;
   logic [ADDR_W-1:0] core_address;
   logic [DATA_W-1:0] core_write_data;
   logic              MemWrite;
   logic              MemRead;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic              busy;
   logic              done;
   logic              timeout;
   logic [31:0]       cycle_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] rom [0:127];
   logic [31:0] ram [0:1023];
   logic [31:0] pc = '0;

   cpu_run_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_WORDS(INIT_WORDS),
      .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES), .HALT_INSN(HALT)
   ) dut (
      .CLK(CLK), .RST(RST), .start(start),
      .init_valid(init_valid), .init_data(init_data), .init_ready(init_ready),
      .cpu_RSTn(cpu_RSTn), .Instruction(Instruction),
      .core_MemWrite(core_MemWrite), .core_MemRead(core_MemRead),
      .core_address(core_address), .core_write_data(core_write_data),
      .MemWrite(MemWrite), .MemRead(MemRead), .address(address), .write_data(write_data),
      .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
   );

   always #5 CLK = ~CLK;

   // Toy core: fetches straight-line code, PC held at 0 while in reset
   always @(posedge CLK) begin
      if (cpu_RSTn !== 1'b1) pc <= '0;
      else                   pc <= pc + 32'd1;
   end
   assign Instruction = rom[pc[6:0]];

   always @(posedge CLK) begin
      if (MemWrite === 1'b1) ram[address] <= write_data;
   end

   typedef struct {
      int halt_pos;
      bit exp_done;
      bit exp_to;
      int exp_count;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference outcome: a halt at word k is fetched in RUN cycle k+1
   function automatic vec_t model(input int halt_pos);
      vec_t r;
      r.halt_pos = halt_pos;
      if (halt_pos >= 0 && halt_pos + 1 <= MAX_CYCLES) begin
         r.exp_done = 1; r.exp_to = 0; r.exp_count = halt_pos + 1;
      end else begin
         r.exp_done = 0; r.exp_to = 1; r.exp_count = MAX_CYCLES;
      end
      return r;
   endfunction

   task automatic applyStimulus(input vec_t v, input bit rnd);
      logic [31:0] data [4];
      int idx;
      int guard;
      bit val;
      for (int i = 0; i < 128; i++) rom[i] = NOP;
      if (v.halt_pos >= 0 && v.halt_pos < 128) rom[v.halt_pos] = HALT;
      for (int i = 0; i < 4; i++) data[i] = rnd ? $urandom : 32'hA + 32'(i);

      @(negedge CLK);
      start = 1'b1; init_valid = 1'b0; core_MemWrite = 1'b0; core_MemRead = 1'b0;
      @(negedge CLK);
      start = 1'b0;
      checkOutput("start_clears_done", done, 1'b0);
      checkOutput("start_clears_timeout", timeout, 1'b0);
      checkOutput("start_clears_count", cycle_count, 32'd0);

      idx = 0;
      guard = 0;
      while (idx < INIT_WORDS && guard < 40) begin
         val = rnd ? 1'($urandom_range(0, 1)) : (guard % 2 == 0);
         init_valid = val;
         init_data  = data[idx];
         core_MemWrite = 1'b1;
         #1;
         checkOutput("load_ready", init_ready, 1'b1);
         checkOutput("load_busy", busy, 1'b1);
         checkOutput("load_core_rstn", cpu_RSTn, 1'b0);
         checkOutput("load_memwrite", MemWrite, val);
         if (val) begin
            checkOutput("load_address", 32'(address), 32'(idx));
            checkOutput("load_wdata", write_data, data[idx]);
            idx++;
         end
         guard++;
         @(negedge CLK);
      end
      checkOutput("load_words_accepted", idx, INIT_WORDS);

      init_valid = 1'b1;
      core_MemWrite = 1'b0;
      for (int k = 0; k < RST_CYCLES; k++) begin
         #1;
         checkOutput("crst_rstn_low", cpu_RSTn, 1'b0);
         checkOutput("crst_ready", init_ready, 1'b0);
         checkOutput("crst_memwrite", MemWrite, 1'b0);
         checkOutput("crst_busy", busy, 1'b1);
         @(negedge CLK);
      end
      init_valid = 1'b0;
      for (int i = 0; i < 4; i++) checkOutput("ram_preload", ram[i], data[i]);

      for (int c = 1; c <= v.exp_count; c++) begin
         core_MemWrite   = 1'($urandom);
         core_MemRead    = 1'($urandom);
         core_address    = ADDR_W'($urandom);
         core_write_data = $urandom;
         start           = (c == 2);
         #1;
         checkOutput("run_rstn_high", cpu_RSTn, 1'b1);
         checkOutput("run_busy", busy, 1'b1);
         checkOutput("run_count", cycle_count, 32'(c - 1));
         checkOutput("run_pass_we", MemWrite, core_MemWrite);
         checkOutput("run_pass_re", MemRead, core_MemRead);
         checkOutput("run_pass_addr", 32'(address), 32'(core_address));
         checkOutput("run_pass_wdata", write_data, core_write_data);
         @(negedge CLK);
      end
      start = 1'b0;
      core_MemWrite = 1'b1;
      core_MemRead  = 1'b1;
      #1;
      checkOutput("stop_rstn_low", cpu_RSTn, 1'b0);
      checkOutput("stop_busy", busy, 1'b0);
      checkOutput("stop_memwrite", MemWrite, 1'b0);
      checkOutput("stop_memread", MemRead, 1'b0);
      checkOutput("stop_count", cycle_count, 32'(v.exp_count));
      @(negedge CLK);
      @(negedge CLK);
      #1;
      checkOutput("final_done", done, v.exp_done);
      checkOutput("final_timeout", timeout, v.exp_to);
      checkOutput("final_count_frozen", cycle_count, 32'(v.exp_count));
      checkOutput("final_rstn_low", cpu_RSTn, 1'b0);
      core_MemWrite = 1'b0;
      core_MemRead  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_time_limit actual=expired required=finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      vec_t table_v [6];
      vec_t rv;
      table_v[0] = '{5,  1'b1, 1'b0, 6};
      table_v[1] = '{-1, 1'b0, 1'b1, 50};
      table_v[2] = '{49, 1'b1, 1'b0, 50};
      table_v[3] = '{0,  1'b1, 1'b0, 1};
      table_v[4] = '{50, 1'b0, 1'b1, 50};
      table_v[5] = '{48, 1'b1, 1'b0, 49};

      for (int i = 0; i < 128; i++) rom[i] = NOP;
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      RST = 1'b1; start = 1'b1; init_valid = 1'b1; init_data = 32'hFFFF_FFFF;
      core_MemWrite = 1'b1; core_MemRead = 1'b1; core_address = '1; core_write_data = '1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #1;
      checkOutput("rst_rstn", cpu_RSTn, 1'b0);
      checkOutput("rst_ready", init_ready, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_timeout", timeout, 1'b0);
      checkOutput("rst_count", cycle_count, 32'd0);
      checkOutput("rst_memwrite", MemWrite, 1'b0);
      checkOutput("rst_memread", MemRead, 1'b0);
      checkOutput("rst_address", 32'(address), 32'd0);
      checkOutput("rst_wdata", write_data, 32'd0);
      RST = 1'b0; start = 1'b0;
      @(negedge CLK);
      #1;
      checkOutput("idle_ignores_valid", MemWrite, 1'b0);
      checkOutput("idle_not_busy", busy, 1'b0);
      core_MemWrite = 1'b0; core_MemRead = 1'b0; init_valid = 1'b0;

      for (int i = 0; i < 6; i++) applyStimulus(table_v[i], 1'b0);

      // Reset in the middle of LOAD, then a complete run must rewrite from address 0
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      init_valid = 1'b1;
      init_data = 32'h5555_0000;
      repeat (2) @(negedge CLK);
      init_valid = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      checkOutput("midload_rst_ready", init_ready, 1'b0);
      checkOutput("midload_rst_busy", busy, 1'b0);
      checkOutput("midload_rst_rstn", cpu_RSTn, 1'b0);
      applyStimulus(table_v[0], 1'b0);

      for (int n = 0; n < 20; n++) begin
         if ($urandom_range(0, 3) == 0) rv = model(-1);
         else                           rv = model(int'($urandom_range(0, 70)));
         applyStimulus(rv, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
